// File: rtl/alu_iterative.sv
// alu_iterative: multi-cycle LEGv8 execute-stage ALU with an NZCV flags register.
// Define ALU_DIV_EN to compile in the iterative SDIV/UDIV datapath.
module alu_iterative #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  input  logic             set_flags,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             illegal,
  output logic [3:0]       flags
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SDIV = 4'b1010;
  localparam logic [3:0] OP_UDIV = 4'b1011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] result_reg, a_reg, b_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sf_reg, illegal_reg, c_reg, v_reg;
  logic [3:0]       flags_reg;

  logic             accept, is_mul, is_div, last_iter;
  logic [WIDTH:0]   add_sum, sub_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_DONE);
  assign result    = result_reg;
  assign illegal   = illegal_reg;
  assign flags     = flags_reg;

  assign accept    = in_valid && (state_reg == S_IDLE);
  assign is_mul    = (alu_control == OP_MUL);
  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

  // Subtraction is a + ~b + 1 so that C reads as "no borrow".
  assign add_sum = {1'b0, a} + {1'b0, b};
  assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] rem_reg, quo_next, div_res, a_mag, b_mag;
  logic [WIDTH:0]   rem_shift, diff;
  logic             neg_reg, div_ge, sdiv_op;

  assign is_div  = (alu_control == OP_SDIV) || (alu_control == OP_UDIV);
  assign sdiv_op = (alu_control == OP_SDIV);
  assign a_mag   = (sdiv_op && a[WIDTH-1]) ? -a : a;
  assign b_mag   = (sdiv_op && b[WIDTH-1]) ? -b : b;

  // a_reg holds the dividend bits still to be shifted in, and collects quotient bits behind them.
  assign rem_shift = {rem_reg, a_reg[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, b_reg};
  assign div_ge    = ~diff[WIDTH];
  assign quo_next  = {a_reg[WIDTH-2:0], div_ge};
  assign div_res   = (b_reg == '0) ? '0 : (neg_reg ? -quo_next : quo_next);

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_reg <= '0;
      neg_reg <= 1'b0;
    end else if (accept) begin
      rem_reg <= '0;
      neg_reg <= sdiv_op && (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (state_reg == S_DIV) begin
      rem_reg <= div_ge ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    end
  end
`else
  assign is_div = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (alu_control)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_sum[WIDTH-1:0];
        alu_c   = sub_sum[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_PASS: alu_res = b;
      OP_NOR:  alu_res = ~(a | b);
      OP_XOR:  alu_res = a ^ b;
      OP_MUL:  alu_res = '0;
`ifdef ALU_DIV_EN
      OP_SDIV, OP_UDIV: alu_res = '0;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = is_mul ? S_MUL : (is_div ? S_DIV : S_DONE);
      S_MUL:  if (last_iter) state_next = S_DONE;
`ifdef ALU_DIV_EN
      S_DIV:  if (last_iter) state_next = S_DONE;
`endif
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_reg  <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      cnt_reg     <= '0;
      sf_reg      <= 1'b0;
      illegal_reg <= 1'b0;
      c_reg       <= 1'b0;
      v_reg       <= 1'b0;
      flags_reg   <= 4'b0000;
    end else begin
      case (state_reg)
        S_IDLE: if (accept) begin
          cnt_reg     <= '0;
          sf_reg      <= set_flags;
          illegal_reg <= alu_ill;
          c_reg       <= alu_c;
          v_reg       <= alu_v;
          result_reg  <= (is_mul || is_div) ? '0 : alu_res;
          a_reg       <= a;
          b_reg       <= b;
`ifdef ALU_DIV_EN
          if (is_div) begin
            a_reg <= a_mag;
            b_reg <= b_mag;
          end
`endif
        end
        S_MUL: begin
          result_reg <= result_reg + (b_reg[0] ? a_reg : '0);
          a_reg      <= a_reg << 1;
          b_reg      <= b_reg >> 1;
          cnt_reg    <= cnt_reg + CNT_W'(1);
        end
`ifdef ALU_DIV_EN
        S_DIV: begin
          a_reg   <= quo_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (last_iter) result_reg <= div_res;
        end
`endif
        S_DONE: if (out_ready && sf_reg && !illegal_reg)
          flags_reg <= {result_reg[WIDTH-1], (result_reg == '0), c_reg, v_reg};
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_iterative.sv
// Directed self-checking bench for alu_iterative: a 64-bit and an 8-bit instance.
module tb_alu_iterative;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, set_flags, out_valid, out_ready, illegal;
  logic [63:0] a, b, result;
  logic [3:0]  alu_control, flags;

  logic        in_valid8, in_ready8, set_flags8, out_valid8, out_ready8, illegal8;
  logic [7:0]  a8, b8, result8;
  logic [3:0]  alu_control8, flags8;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [3:0] fl_model [2];

  alu_iterative #(.WIDTH(64)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_control(alu_control), .set_flags(set_flags),
    .result(result), .out_valid(out_valid), .out_ready(out_ready),
    .illegal(illegal), .flags(flags)
  );

  alu_iterative #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .alu_control(alu_control8), .set_flags(set_flags8),
    .result(result8), .out_valid(out_valid8), .out_ready(out_ready8),
    .illegal(illegal8), .flags(flags8)
  );

  typedef struct {
    string       tag;
    logic [3:0]  op;
    logic [63:0] av;
    logic [63:0] bv;
    bit          sf;
    logic [63:0] er;
    logic [3:0]  efl;
  } vec_t;
  vec_t vecs [11];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_res(input bit w8);
    return w8 ? {56'd0, result8} : result;
  endfunction
  function automatic logic dut_ov(input bit w8);
    return w8 ? out_valid8 : out_valid;
  endfunction
  function automatic logic dut_rdy(input bit w8);
    return w8 ? in_ready8 : in_ready;
  endfunction
  function automatic logic dut_ill(input bit w8);
    return w8 ? illegal8 : illegal;
  endfunction
  function automatic logic [3:0] dut_fl(input bit w8);
    return w8 ? flags8 : flags;
  endfunction

  task automatic drive_in(input bit w8, input logic v, input logic [3:0] op,
                          input logic [63:0] av, input logic [63:0] bv, input logic sf);
    if (w8) begin
      in_valid8 = v; alu_control8 = op; a8 = av[7:0]; b8 = bv[7:0]; set_flags8 = sf;
    end else begin
      in_valid = v; alu_control = op; a = av; b = bv; set_flags = sf;
    end
  endtask

  task automatic do_check(input string tag, input bit w8, input logic [3:0] op,
                          input logic [63:0] av, input logic [63:0] bv, input bit sf,
                          input int hold, input logic [63:0] er, input logic eill,
                          input int elat, input logic [3:0] efl);
    int lat;
    @(negedge clk);
    check_eq({tag, ":in_ready"}, 64'(dut_rdy(w8)), 64'd1);
    drive_in(w8, 1'b1, op, av, bv, sf);
    @(posedge clk);
    #1 drive_in(w8, 1'b0, 4'b0000, 64'd0, 64'd0, 1'b0);
    lat = 1;
    @(negedge clk);
    while (!dut_ov(w8) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, ":out_valid"}, 64'(dut_ov(w8)), 64'd1);
    check_eq({tag, ":latency"}, 64'(lat), 64'(elat));
    check_eq({tag, ":result"}, dut_res(w8), er);
    check_eq({tag, ":illegal"}, 64'(dut_ill(w8)), 64'(eill));
    for (int i = 0; i < hold; i++) begin
      // A competing request while busy must be dropped.
      drive_in(w8, 1'b1, 4'b0010, 64'h5A5A, 64'h1, 1'b1);
      @(negedge clk);
      check_eq({tag, ":hold_valid"}, 64'(dut_ov(w8)), 64'd1);
      check_eq({tag, ":hold_result"}, dut_res(w8), er);
      check_eq({tag, ":hold_illegal"}, 64'(dut_ill(w8)), 64'(eill));
      check_eq({tag, ":hold_in_ready"}, 64'(dut_rdy(w8)), 64'd0);
      check_eq({tag, ":hold_flags"}, 64'(dut_fl(w8)), 64'(fl_model[w8]));
    end
    if (w8) out_ready8 = 1'b1; else out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready8 = 1'b0;
    out_ready  = 1'b0;
    drive_in(w8, 1'b0, 4'b0000, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    check_eq({tag, ":flags"}, 64'(dut_fl(w8)), 64'(efl));
    check_eq({tag, ":idle_ready"}, 64'(dut_rdy(w8)), 64'd1);
    check_eq({tag, ":idle_valid"}, 64'(dut_ov(w8)), 64'd0);
    fl_model[w8] = efl;
    $display("[TB] %s w%0d op=%b a=%h b=%h -> result=%h illegal=%b lat=%0d flags=%b",
             tag, w8 ? 8 : 64, op, av, bv, dut_res(w8), dut_ill(w8), lat, dut_fl(w8));
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    out_ready = 1'b0;
    out_ready8 = 1'b0;
    drive_in(1'b0, 1'b0, 4'b0000, 64'd0, 64'd0, 1'b0);
    drive_in(1'b1, 1'b0, 4'b0000, 64'd0, 64'd0, 1'b0);
    fl_model[0] = 4'b0000;
    fl_model[1] = 4'b0000;

    vecs[0]  = '{"add_ovf",  4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 4'b1001};
    vecs[1]  = '{"sub_eq",   4'b0110, 64'd5, 64'd5, 1'b1, 64'd0, 4'b0110};
    vecs[2]  = '{"sub_nosf", 4'b0110, 64'd3, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0110};
    vecs[3]  = '{"sub_ovf",  4'b0110, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    vecs[4]  = '{"sub_brw",  4'b0110, 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
    vecs[5]  = '{"add_cry",  4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'd0, 4'b0110};
    vecs[6]  = '{"or",       4'b0001, 64'hF0, 64'h0F, 1'b1, 64'hFF, 4'b0000};
    vecs[7]  = '{"nor",      4'b1100, 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
    vecs[8]  = '{"xor",      4'b1101, 64'hF0, 64'h3C, 1'b1, 64'hCC, 4'b0000};
    vecs[9]  = '{"pass_b",   4'b0111, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
    vecs[10] = '{"and",      4'b0000, 64'hFF00, 64'h0F0F, 1'b1, 64'h0F00, 4'b0000};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst:in_ready", 64'(in_ready), 64'd1);
    check_eq("rst:out_valid", 64'(out_valid), 64'd0);
    check_eq("rst:result", result, 64'd0);
    check_eq("rst:illegal", 64'(illegal), 64'd0);
    check_eq("rst:flags", 64'(flags), 64'd0);
    check_eq("rst8:in_ready", 64'(in_ready8), 64'd1);
    check_eq("rst8:flags", 64'(flags8), 64'd0);

    for (int i = 0; i < 11; i++)
      do_check(vecs[i].tag, 1'b0, vecs[i].op, vecs[i].av, vecs[i].bv, vecs[i].sf,
               0, vecs[i].er, 1'b0, 1, vecs[i].efl);

    do_check("mul_neg", 1'b0, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b1, 5,
             64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 65, 4'b1000);
    do_check("undef", 1'b0, 4'b1111, 64'd1, 64'd1, 1'b1, 0, 64'd0, 1'b1, 1, 4'b1000);

`ifdef ALU_DIV_EN
    do_check("sdiv_neg", 1'b0, 4'b1010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 0,
             64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65, 4'b1000);
    do_check("udiv_by0", 1'b0, 4'b1011, 64'd100, 64'd0, 1'b1, 0, 64'd0, 1'b0, 65, 4'b0100);
    do_check("sdiv_min", 1'b0, 4'b1010, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0,
             64'h8000_0000_0000_0000, 1'b0, 65, 4'b1000);
    do_check("udiv", 1'b0, 4'b1011, 64'd100, 64'd7, 1'b0, 0, 64'd14, 1'b0, 65, 4'b1000);
`else
    do_check("sdiv_undef", 1'b0, 4'b1010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 0, 64'd0, 1'b1, 1, 4'b1000);
    do_check("udiv_undef", 1'b0, 4'b1011, 64'd100, 64'd7, 1'b1, 0, 64'd0, 1'b1, 1, 4'b1000);
`endif

    // Abort a MUL with reset on the 20th edge after acceptance.
    @(negedge clk);
    drive_in(1'b0, 1'b1, 4'b1000, 64'd3, 64'd5, 1'b1);
    @(posedge clk);
    #1 drive_in(1'b0, 1'b0, 4'b0000, 64'd0, 64'd0, 1'b0);
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("abort:out_valid", 64'(out_valid), 64'd0);
    check_eq("abort:in_ready", 64'(in_ready), 64'd1);
    check_eq("abort:flags", 64'(flags), 64'd0);
    check_eq("abort:result", result, 64'd0);
    fl_model[0] = 4'b0000;
    fl_model[1] = 4'b0000;
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("abort:no_stale_valid", 64'(seen), 64'd0);
    $display("[TB] abort mul after reset: out_valid=%b flags=%b", out_valid, flags);

    do_check("and8", 1'b1, 4'b0000, 64'hF0, 64'h3C, 1'b1, 0, 64'h30, 1'b0, 1, 4'b0000);
    do_check("and64", 1'b0, 4'b0000, 64'hF0, 64'h3C, 1'b1, 0, 64'h30, 1'b0, 1, 4'b0000);
    do_check("mul8", 1'b1, 4'b1000, 64'hFD, 64'h07, 1'b1, 0, 64'hEB, 1'b0, 9, 4'b1000);
    do_check("add8_ovf", 1'b1, 4'b0010, 64'h7F, 64'h01, 1'b1, 0, 64'h80, 1'b0, 1, 4'b1001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
